alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Host-side command sequencer for the 3-bit-select ALU core. It accepts operation commands over a valid/ready interface and buffers them in a 4-entry FIFO. It drives the ALU's packed operand bus {sel[2:0], A[2:0], B[1:0]} one command at a time, captures the ALU result and carry, and returns them over a valid/ready response interface with a wrapping tag. It sits between the pad-level command source and the combinational ALU, the producer end of the packed operand byte the ALU consumes.

## Interface
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- clk  in  1  single clock; every register is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted on clk edge when cmd_valid & cmd_ready.
- cmd_sel  in  3  operation select.
- cmd_a  in  3  operand A.
- cmd_b  in  2  operand B.
- alu_bus  out  8  registered packed operand byte {sel, A, B} to ALU.
- alu_result  in  8  ALU result (combinational from alu_bus).
- alu_cout  in  1  ALU carry out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed on edge when rsp_valid & rsp_ready.
- rsp_data  out  8  captured alu_result.
- rsp_cout  out  1  captured alu_cout.
- rsp_tag  out  2  issue sequence number of this response.
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE.
- op_count  out  8  completed responses, wraps 255->0.

## Operation
- cmd_ready = ena & !fifo_full. This is combinational and does not account for a same-cycle pop.
- Push on cmd handshake stores {cmd_sel, cmd_a, cmd_b} at the write pointer. Pointers are log2(DEPTH)+1 bits. Full/empty are decided by pointer MSB compare.
- FSM states: IDLE, DRIVE, CAPTURE, HOLD.
  - IDLE: if FIFO non-empty, pop the head into alu_bus and go to DRIVE. Otherwise stay.
  - DRIVE: alu_bus is stable and the ALU settles. Go to CAPTURE unconditionally.
  - CAPTURE: latch alu_result into rsp_data and alu_cout into rsp_cout. Set rsp_tag = issue_cnt and increment issue_cnt (2-bit, wraps 3->0). Set rsp_valid=1. Go to HOLD.
  - HOLD: rsp_valid, rsp_data, rsp_cout and rsp_tag are held stable until the handshake. On handshake, clear rsp_valid and increment op_count. Then, if the FIFO is non-empty, pop into alu_bus and go to DRIVE; otherwise go to IDLE.
- alu_bus changes only on a pop and holds its last value otherwise.
- ena low: no push, no pop, FSM and counters hold, cmd_ready=0. rsp_valid keeps its value, but no handshake completes while ena is low.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Push into an empty FIFO while in IDLE: the entry becomes visible to IDLE on the following cycle (no bypass).

## Timing
- Reset values:
  - alu_bus=8'h00, rsp_valid=0, rsp_data=8'h00, rsp_cout=0, rsp_tag=0, op_count=0, busy=0, FSM=IDLE.
  - FIFO empty, issue_cnt=0.
  - cmd_ready=ena.
- Latency, idle sequencer: command handshake at edge E0. Pop and alu_bus load at E1. Capture at E3. rsp_valid is high in the cycle after E3.
- Throughput with rsp_ready held high: one response per 3 cycles (HOLD->DRIVE->CAPTURE->HOLD).
- Reset mid-operation: all state clears immediately, pending commands and responses are discarded, and alu_bus returns to 8'h00.

## Test plan
- Single op after reset, ena=1: cmd sel=0, A=5, B=3 at edge 0. Required: alu_bus=8'h17 after edge 1. With the bench model returning alu_result = A+B = 8'h08, rsp_valid rises after edge 3 with rsp_data=8'h08, rsp_tag=0. op_count=1 after the handshake.
- Fill: hold rsp_ready=0 and push 5 commands back-to-back. Required:
  - 1 command pops to the FSM.
  - cmd_ready drops after the 5th accepted push (4 buffered + 1 in flight).
  - A 6th cmd_valid is not accepted.
- Backpressure: hold rsp_ready=0 for 10 cycles in HOLD. Required: rsp_data, rsp_tag and alu_bus are stable. Releasing rsp_ready completes exactly one handshake.
- Tag/counter wrap: run 257 commands. Required: rsp_tag cycles 0,1,2,3,0…, and op_count reads 8'h01 at the end.
- ena gating: drop ena in DRIVE for 3 cycles. Required: cmd_ready=0, the FSM stays in DRIVE, and the response is correct after ena returns.
- Async reset in HOLD with 2 queued commands. Required: rsp_valid=0, busy=0 and alu_bus=8'h00 immediately, with no responses after release.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between the host command source and alu_op_sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [2:0] cmd_a;
  logic [1:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout;
  logic [1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_tag
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands in a small FIFO, drives the packed operand byte to the ALU one
// command at a time and returns the captured result with a wrapping issue tag.
//
// state   | meaning
// IDLE    | nothing in flight, waiting for a buffered command
// DRIVE   | alu_bus loaded, ALU settling
// CAPTURE | latch ALU result/carry into the response registers
// HOLD    | response presented, waiting for rsp_ready
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  alu_op_sequencer_if.slave   bus,
  output logic [7:0]          alu_bus,
  input  logic [7:0]          alu_result,
  input  logic                alu_cout,
  output logic                busy,
  output logic [7:0]          op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        capture;
  logic        rsp_done;

  logic [1:0]  issue_cnt;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_cout_q;
  logic [1:0]  rsp_tag_q;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.cmd_ready = ena & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_tag   = rsp_tag_q;

  assign busy = ~fifo_empty | (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {bus.cmd_sel, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // All transitions are gated by ena so a low enable freezes the sequencer in place.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    if (ena) begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_DRIVE;
          end
        end
        S_DRIVE: begin
          state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            rsp_done = 1'b1;
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = S_DRIVE;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_bus     <= 8'h00;
      issue_cnt   <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_cout_q  <= 1'b0;
      rsp_tag_q   <= 2'd0;
      op_count    <= 8'h00;
    end else begin
      if (pop) begin
        alu_bus <= fifo_mem[rd_ptr[AW-1:0]];
      end
      if (capture) begin
        rsp_data_q  <= alu_result;
        rsp_cout_q  <= alu_cout;
        rsp_tag_q   <= issue_cnt;
        issue_cnt   <= issue_cnt + 2'd1;
        rsp_valid_q <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        op_count    <= op_count + 8'd1;
      end
    end
  end

endmodule
